// File: rtl/ysyx_22051145_pc_gen.sv
//------------------------------------------------------------------------------
// Module   : ysyx_22051145_pc_gen
// Brief    : Instruction-fetch front end: PC, IF/ID register, redirects, halt.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_22051145_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] fetch_addr,
    input  logic [31:0] fetch_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        trap_valid,
    input  logic [63:0] trap_target,
    input  logic        halt_req,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_misalign,
    output logic        halted,
    output logic [63:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_misalign;
    logic [63:0] r_fetch_count;

    logic        w_trap_take;
    logic        w_redirect_take;
    logic        w_fire;
    logic        w_misaligned;

    assign w_trap_take     = trap_valid && (r_state != S_BOOT);
    assign w_redirect_take = redirect_valid && !trap_valid && (r_state == S_RUN);
    assign w_fire          = (r_state == S_RUN) && (!r_id_valid || id_ready)
                             && !trap_valid && !redirect_valid;
    assign w_misaligned    = (r_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_id_pc       <= 64'd0;
            r_id_inst     <= 32'd0;
            r_id_valid    <= 1'b0;
            r_id_misalign <= 1'b0;
            r_fetch_count <= 64'd0;
        end else if (w_trap_take) begin
            // Trap beats halt_req and is the only way out of HALT.
            r_pc       <= trap_target;
            r_id_valid <= 1'b0;
            r_state    <= S_RUN;
        end else if (w_redirect_take) begin
            r_pc       <= redirect_target;
            r_id_valid <= 1'b0;
            if (halt_req) begin
                r_state <= S_HALT;
            end
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_fire) begin
                        r_id_pc       <= r_pc;
                        r_id_valid    <= 1'b1;
                        r_fetch_count <= r_fetch_count + 64'd1;
                        if (w_misaligned) begin
                            // Poisoned entry: PC stays put until a trap moves it.
                            r_id_inst     <= NOP_INST;
                            r_id_misalign <= 1'b1;
                            r_state       <= S_HALT;
                        end else begin
                            r_id_inst     <= fetch_data;
                            r_id_misalign <= 1'b0;
                            r_pc          <= r_pc + 64'd4;
                        end
                    end
                    if (halt_req) begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (id_ready) begin
                        r_id_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign fetch_addr  = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_inst     = r_id_inst;
    assign id_misalign = r_id_misalign;
    assign halted      = (r_state == S_HALT);
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22051145_pc_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_22051145_pc_gen
// Brief    : Self-checking bench for ysyx_22051145_pc_gen with reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_22051145_pc_gen;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        trap_valid;
    logic [63:0] trap_target;
    logic        halt_req;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misalign;
    logic        halted;
    logic [63:0] fetch_count;

    int total = 0;
    int bad   = 0;
    bit const_mem = 1'b1;

    ysyx_22051145_pc_gen dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .halt_req(halt_req),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_misalign(id_misalign),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: constant word or an address hash.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (const_mem) return 32'h1111_1111;
        return a[31:0] * 32'h9E37_79B1 ^ a[63:32];
    endfunction

    assign fetch_data = mem_word(fetch_addr);

    // Reference model: 0=BOOT 1=RUN 2=HALT
    int          m_mode;
    logic [63:0] m_pc, m_id_pc, m_cnt;
    logic [31:0] m_inst;
    logic        m_valid, m_mis;

    task automatic model_reset();
        m_mode = 0; m_pc = C_RESET_PC; m_id_pc = 0; m_inst = 0;
        m_valid = 0; m_mis = 0; m_cnt = 0;
    endtask

    // Advance model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        int          n_mode  = m_mode;
        logic [63:0] n_pc    = m_pc, n_id_pc = m_id_pc, n_cnt = m_cnt;
        logic [31:0] n_inst  = m_inst;
        logic        n_valid = m_valid, n_mis = m_mis;
        if (m_mode == 0) begin
            n_mode = 1;
        end else if (trap_valid) begin
            n_pc = trap_target; n_valid = 0; n_mode = 1;
        end else if (m_mode == 1 && redirect_valid) begin
            n_pc = redirect_target; n_valid = 0;
            if (halt_req) n_mode = 2;
        end else if (m_mode == 1) begin
            if (!m_valid || id_ready) begin
                n_id_pc = m_pc; n_valid = 1; n_cnt = m_cnt + 1;
                if (m_pc % 4 != 0) begin
                    n_inst = C_NOP; n_mis = 1; n_mode = 2;
                end else begin
                    n_inst = mem_word(m_pc); n_mis = 0; n_pc = m_pc + 4;
                end
            end
            if (halt_req) n_mode = 2;
        end else if (id_ready) begin
            n_valid = 0;
        end
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_id_pc = n_id_pc; m_cnt = n_cnt;
        m_inst = n_inst; m_valid = n_valid; m_mis = n_mis;
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 0; redirect_target = 0;
        trap_valid = 0; trap_target = 0;
        halt_req = 0; id_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        total++;
        if (fetch_addr !== C_RESET_PC || id_valid !== 0 || id_pc !== 0 || id_inst !== 0 ||
            id_misalign !== 0 || halted !== 0 || fetch_count !== 0) begin
            bad++;
            $display("FAIL reset: addr=%h v=%b pc=%h inst=%h mis=%b h=%b cnt=%0d want addr=%h all zero",
                     fetch_addr, id_valid, id_pc, id_inst, id_misalign, halted, fetch_count, C_RESET_PC);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [63:0] exp_addr [4] = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (fetch_addr !== exp_addr[i]) begin
                bad++;
                $display("FAIL seq_addr[%0d]: got=%h want=%h", i, fetch_addr, exp_addr[i]);
            end
        end
        total++;
        if (fetch_count !== 64'd3 || id_pc !== 64'h8000_0008 || id_inst !== 32'h1111_1111 || id_valid !== 1) begin
            bad++;
            $display("FAIL seq_entry: cnt=%0d pc=%h inst=%h v=%b want cnt=3 pc=80000008 inst=11111111 v=1",
                     fetch_count, id_pc, id_inst, id_valid);
        end
    endtask

    task automatic test_stall();
        logic [63:0] held_pc, held_addr;
        held_pc = id_pc; held_addr = fetch_addr;
        id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (id_pc !== held_pc || fetch_addr !== held_addr || id_valid !== 1 || id_inst !== 32'h1111_1111) begin
                bad++;
                $display("FAIL stall[%0d]: pc=%h addr=%h v=%b want pc=%h addr=%h v=1",
                         i, id_pc, fetch_addr, id_valid, held_pc, held_addr);
            end
        end
        id_ready = 1;
        tick();
        total++;
        if (id_pc !== held_addr || fetch_addr !== held_addr + 4) begin
            bad++;
            $display("FAIL stall_resume: pc=%h addr=%h want pc=%h addr=%h",
                     id_pc, fetch_addr, held_addr, held_addr + 4);
        end
    endtask

    task automatic test_redirect();
        id_ready = 0;
        tick();
        redirect_valid = 1; redirect_target = 64'h8000_0100;
        tick();
        redirect_valid = 0; id_ready = 1;
        total++;
        if (id_valid !== 0 || fetch_addr !== 64'h8000_0100) begin
            bad++;
            $display("FAIL redirect_flush: v=%b addr=%h want v=0 addr=80000100", id_valid, fetch_addr);
        end
        tick();
        total++;
        if (id_pc !== 64'h8000_0100 || id_valid !== 1) begin
            bad++;
            $display("FAIL redirect_entry: pc=%h v=%b want pc=80000100 v=1", id_pc, id_valid);
        end
    endtask

    task automatic test_trap_priority();
        trap_valid = 1; trap_target = 64'h8000_0200;
        redirect_valid = 1; redirect_target = 64'h8000_0300;
        halt_req = 1;
        tick();
        idle_inputs();
        total++;
        if (fetch_addr !== 64'h8000_0200 || id_valid !== 0 || halted !== 0) begin
            bad++;
            $display("FAIL trap_priority: addr=%h v=%b h=%b want addr=80000200 v=0 h=0",
                     fetch_addr, id_valid, halted);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1; redirect_target = 64'h8000_0102;
        tick();
        redirect_valid = 0;
        tick();
        tick();
        total++;
        if (id_inst !== C_NOP || id_misalign !== 1 || halted !== 1 || fetch_addr !== 64'h8000_0102 ||
            id_pc !== 64'h8000_0102) begin
            bad++;
            $display("FAIL misalign: inst=%h mis=%b h=%b addr=%h pc=%h want 00000013 1 1 80000102 80000102",
                     id_inst, id_misalign, halted, fetch_addr, id_pc);
        end
        redirect_valid = 1; redirect_target = 64'h8000_0500; halt_req = 1;
        tick();
        redirect_valid = 0; halt_req = 0;
        total++;
        if (halted !== 1 || fetch_addr !== 64'h8000_0102 || id_valid !== 0) begin
            bad++;
            $display("FAIL halt_ignore: h=%b addr=%h v=%b want h=1 addr=80000102 v=0", halted, fetch_addr, id_valid);
        end
        trap_valid = 1; trap_target = 64'h8000_0400;
        tick();
        trap_valid = 0;
        tick();
        total++;
        if (halted !== 0 || id_pc !== 64'h8000_0400 || id_misalign !== 0 || fetch_addr !== 64'h8000_0404) begin
            bad++;
            $display("FAIL trap_exit: h=%b pc=%h mis=%b addr=%h want 0 80000400 0 80000404",
                     halted, id_pc, id_misalign, fetch_addr);
        end
    endtask

    task automatic test_wrap();
        trap_valid = 1; trap_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        trap_valid = 0;
        tick();
        total++;
        if (fetch_addr !== 64'd0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL pc_wrap: addr=%h pc=%h want addr=0 pc=fffffffffffffffc", fetch_addr, id_pc);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2 rst_n = 0;
        #1;
        total++;
        if (id_valid !== 0 || fetch_addr !== C_RESET_PC || fetch_count !== 0 || halted !== 0) begin
            bad++;
            $display("FAIL async_reset: v=%b addr=%h cnt=%0d h=%b want v=0 addr=%h cnt=0 h=0",
                     id_valid, fetch_addr, fetch_count, halted, C_RESET_PC);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_random();
        int errs = 0;
        const_mem = 1'b0;
        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom % 4) != 0;
            halt_req       = ($urandom % 25) == 0;
            trap_valid     = ($urandom % 20) == 0;
            redirect_valid = ($urandom % 10) == 0;
            trap_target    = 64'h8000_0000 + 64'(($urandom % 256) * 4);
            redirect_target = 64'h8000_1000 + 64'(($urandom % 256) * 4) + 64'(($urandom % 12 == 0) ? 2 : 0);
            if ($urandom % 30 == 0) trap_target = 64'hFFFF_FFFF_FFFF_FFF8;
            tick();
            total++;
            if ({fetch_addr, id_valid, id_pc, id_inst, id_misalign, halted, fetch_count} !==
                {m_pc, m_valid, m_id_pc, m_inst, m_mis, (m_mode == 2), m_cnt}) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random[%0d]: addr=%h v=%b pc=%h inst=%h mis=%b h=%b cnt=%0d want %h %b %h %h %b %b %0d",
                             i, fetch_addr, id_valid, id_pc, id_inst, id_misalign, halted, fetch_count,
                             m_pc, m_valid, m_id_pc, m_inst, m_mis, (m_mode == 2), m_cnt);
                errs++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_trap_priority();
        test_misalign();
        test_wrap();
        test_async_reset();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
